// File: rtl/pll_dyn_cfg.sv
// PLL dynamic-reconfiguration writer and lock supervisor with retry on lock timeout.
// Optional: define PLL_READBACK_EN to read back and verify every byte before releasing the PLL.
module pll_dyn_cfg #(
  parameter  int NUM_REGS     = 4,
  parameter  int RESET_CYCLES = 16,
  parameter  int LOCK_TIMEOUT = 65535,
  parameter  int LOCK_FILTER  = 256,
  parameter  int MAX_RETRY    = 3,
  localparam int RW           = $clog2(MAX_RETRY + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [8*NUM_REGS-1:0] cfg_data,
  input  logic                  pll_lock,
  output logic                  pll_reset,
  output logic [1:0]            md_opc,
  output logic                  md_ainc,
  output logic [7:0]            md_wdi,
  input  logic [7:0]            md_rdo,
  output logic                  locked,
  output logic                  busy,
  output logic                  error,
  output logic [RW-1:0]         retry_cnt
);

  localparam int IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CMAX = (RESET_CYCLES > LOCK_FILTER) ? RESET_CYCLES : LOCK_FILTER;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(LOCK_TIMEOUT + 1);
  localparam int DW   = 8 * NUM_REGS;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REGS - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] FLT_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ARESET    = 4'd1,
    S_CLEAR     = 4'd2,
    S_WRITE     = 4'd3,
    S_WINC      = 4'd4,
    S_RCLEAR    = 4'd5,
    S_READ      = 4'd6,
    S_RCMP      = 4'd7,
    S_RELEASE   = 4'd8,
    S_WAIT_LOCK = 4'd9,
    S_FILTER    = 4'd10,
    S_LOCKED    = 4'd11,
    S_FAIL      = 4'd12
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [1:0]      sync_q;
  logic            lock_s, accept_s, retry_req_s;
  logic            pll_reset_q, cfg_ready_q, md_ainc_q, locked_q, busy_q, error_q;
  logic [1:0]      md_opc_q;
  logic [7:0]      md_wdi_q;

  function automatic logic [7:0] byte_at(input logic [DW-1:0] d, input logic [IW-1:0] i);
    return d[{i, 3'b000} +: 8];
  endfunction

  assign lock_s   = sync_q[1];
  assign accept_s = cfg_valid & cfg_ready_q;

`ifndef PLL_READBACK_EN
  logic rdo_unused_s;
  assign rdo_unused_s = ^md_rdo;
`endif

  // Lock synchroniser: pll_lock is asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], pll_lock};
  end

  // Next-state logic; a new request pre-empts everything else.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    retry_req_s = 1'b0;
    if (accept_s) begin
      data_d  = cfg_data;
      retry_d = '0;
      cnt_d   = '0;
      state_d = S_ARESET;
    end else begin
      case (state_q)
        S_ARESET: begin
          if (cnt_q == RST_LAST) state_d = S_CLEAR;
          else                   cnt_d   = cnt_q + CW'(1);
        end
        S_CLEAR: begin
          idx_d   = '0;
          state_d = S_WRITE;
        end
        S_WRITE: state_d = S_WINC;
        S_WINC: begin
          if (idx_q == LAST_IDX) begin
`ifdef PLL_READBACK_EN
            state_d = S_RCLEAR;
`else
            state_d = S_RELEASE;
`endif
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_WRITE;
          end
        end
`ifdef PLL_READBACK_EN
        S_RCLEAR: begin
          idx_d   = '0;
          state_d = S_READ;
        end
        S_READ: state_d = S_RCMP;
        // A readback mismatch is a configuration fault, so no retry is attempted.
        S_RCMP: begin
          if (md_rdo != byte_at(data_q, idx_q)) state_d = S_FAIL;
          else if (idx_q == LAST_IDX)           state_d = S_RELEASE;
          else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_READ;
          end
        end
`endif
        S_RELEASE: begin
          tmo_d   = '0;
          state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_q == TMO_LAST) retry_req_s = 1'b1;
          else if (lock_s) begin
            cnt_d   = '0;
            state_d = S_FILTER;
          end else begin
            state_d = S_WAIT_LOCK;
          end
        end
        // The timeout keeps running here so a chattering lock still ends in a retry.
        S_FILTER: begin
          tmo_d = tmo_q + TW'(1);
          if (!lock_s)                state_d     = S_WAIT_LOCK;
          else if (cnt_q == FLT_LAST) state_d     = S_LOCKED;
          else if (tmo_q == TMO_LAST) retry_req_s = 1'b1;
          else                        cnt_d       = cnt_q + CW'(1);
        end
        S_LOCKED: begin
          if (!lock_s) begin
            tmo_d   = '0;
            state_d = S_WAIT_LOCK;
          end else begin
            state_d = S_LOCKED;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_IDLE;
      endcase
      if (retry_req_s) begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + RW'(1);
          cnt_d   = '0;
          state_d = S_ARESET;
        end else begin
          state_d = S_FAIL;
        end
      end else begin
        retry_d = retry_q;
      end
    end
  end

  // Control state and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
    end
  end

  // Outputs are decoded from the next state, so they change together with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_reset_q <= 1'b1;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      md_ainc_q   <= 1'b0;
      md_wdi_q    <= 8'h00;
      md_opc_q    <= 2'b00;
    end else begin
      pll_reset_q <= !(state_d inside {S_WAIT_LOCK, S_FILTER, S_LOCKED});
      cfg_ready_q <= state_d inside {S_IDLE, S_LOCKED, S_FAIL};
      busy_q      <= !(state_d inside {S_IDLE, S_LOCKED, S_FAIL});
      locked_q    <= (state_d == S_LOCKED);
      error_q     <= (state_d == S_FAIL);
      md_ainc_q   <= (state_d == S_WINC) || (state_d == S_RCMP);
      md_wdi_q    <= (state_d == S_WRITE) ? byte_at(data_d, idx_d) : 8'h00;
      case (state_d)
        S_CLEAR, S_RCLEAR: md_opc_q <= 2'b11;
        S_WRITE:           md_opc_q <= 2'b01;
        S_READ:            md_opc_q <= 2'b10;
        default:           md_opc_q <= 2'b00;
      endcase
    end
  end

  assign pll_reset = pll_reset_q;
  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign locked    = locked_q;
  assign error     = error_q;
  assign md_ainc   = md_ainc_q;
  assign md_wdi    = md_wdi_q;
  assign md_opc    = md_opc_q;
  assign retry_cnt = retry_q;

endmodule
